// File: rtl/npc_stage_ctrl.sv
// Multi-cycle instruction sequencer: walks IF/ID/EX/LS/WB stages, retires instructions,
// and stops on ebreak (HALT) or a stuck stage (ERR, watchdog).
module npc_stage_ctrl #(
  parameter int unsigned TIMEOUT = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        ifu_done,
  input  logic        idu_done,
  input  logic        exu_done,
  input  logic        lsu_done,
  input  logic        mem_access,
  input  logic        is_ebreak,
  input  logic        is_ecall,
  output logic        ifu_start,
  output logic        idu_start,
  output logic        exu_start,
  output logic        lsu_start,
  output logic        reg_wen,
  output logic        pc_we,
  output logic        pc_sel_trap,
  output logic        halted,
  output logic        timeout,
  output logic [2:0]  state,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StIf   = 3'd1,
    StId   = 3'd2,
    StEx   = 3'd3,
    StLs   = 3'd4,
    StWb   = 3'd5,
    StHalt = 3'd6,
    StErr  = 3'd7
  } state_e;

  localparam logic [7:0] WdogLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        entry_q;
  logic        mem_q, mem_d;
  logic        ecall_q, ecall_d;
  logic [7:0]  wdog_q, wdog_d;
  logic [31:0] retired_q, retired_d;
  logic        in_stage;
  logic        stage_done;

  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    ecall_d    = ecall_q;
    retired_d  = retired_q;
    in_stage   = 1'b0;
    stage_done = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (run) state_d = StIf;
      end
      StIf: begin
        in_stage   = 1'b1;
        stage_done = ifu_done;
        if (ifu_done) state_d = StId;
      end
      StId: begin
        in_stage   = 1'b1;
        stage_done = idu_done;
        if (idu_done) begin
          mem_d   = mem_access;
          ecall_d = is_ecall;
          // ebreak takes priority over ecall when both decode
          state_d = is_ebreak ? StHalt : StEx;
        end
      end
      StEx: begin
        in_stage   = 1'b1;
        stage_done = exu_done;
        if (exu_done) state_d = mem_q ? StLs : StWb;
      end
      StLs: begin
        in_stage   = 1'b1;
        stage_done = lsu_done;
        if (lsu_done) state_d = StWb;
      end
      StWb: begin
        retired_d = retired_q + 32'd1;
        state_d   = run ? StIf : StIdle;
      end
      default: ;
    endcase

    if (in_stage && !stage_done && (wdog_q == WdogLast)) state_d = StErr;

    if ((state_d == StIf) && (state_q != StIf)) begin
      mem_d   = 1'b0;
      ecall_d = 1'b0;
    end

    // Counts consecutive stalled cycles; any state change restarts it
    wdog_d = ((state_d != state_q) || !in_stage) ? 8'd0 : wdog_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      entry_q   <= 1'b0;
      mem_q     <= 1'b0;
      ecall_q   <= 1'b0;
      wdog_q    <= 8'd0;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      entry_q   <= (state_d != state_q);
      mem_q     <= mem_d;
      ecall_q   <= ecall_d;
      wdog_q    <= wdog_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    ifu_start   = entry_q && (state_q == StIf);
    idu_start   = entry_q && (state_q == StId);
    exu_start   = entry_q && (state_q == StEx);
    lsu_start   = entry_q && (state_q == StLs);
    pc_we       = (state_q == StWb);
    reg_wen     = (state_q == StWb) && !ecall_q;
    pc_sel_trap = (state_q == StWb) && ecall_q;
    halted      = (state_q == StHalt) || (state_q == StErr);
    timeout     = (state_q == StErr);
    state       = state_q;
    retired     = retired_q;
  end

endmodule

// File: tb/tb_npc_stage_ctrl.sv
// Bench for npc_stage_ctrl: vector table for basic sequencing, hand sequences for
// ecall, ebreak, reset mid-instruction and watchdog expiry.
module tb_npc_stage_ctrl;

  logic        clk;
  logic        rst, run;
  logic        ifu_done, idu_done, exu_done, lsu_done;
  logic        mem_access, is_ebreak, is_ecall;
  logic        ifu_start, idu_start, exu_start, lsu_start;
  logic        reg_wen, pc_we, pc_sel_trap, halted, timeout;
  logic [2:0]  state;
  logic [31:0] retired;

  npc_stage_ctrl #(.TIMEOUT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .ifu_done    (ifu_done),
    .idu_done    (idu_done),
    .exu_done    (exu_done),
    .lsu_done    (lsu_done),
    .mem_access  (mem_access),
    .is_ebreak   (is_ebreak),
    .is_ecall    (is_ecall),
    .ifu_start   (ifu_start),
    .idu_start   (idu_start),
    .exu_start   (exu_start),
    .lsu_start   (lsu_start),
    .reg_wen     (reg_wen),
    .pc_we       (pc_we),
    .pc_sel_trap (pc_sel_trap),
    .halted      (halted),
    .timeout     (timeout),
    .state       (state),
    .retired     (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // done = {ifu,idu,exu,lsu}; starts = {ifu,idu,exu,lsu}; wb = {reg_wen,pc_we,pc_sel_trap};
  // ht = {halted,timeout}. Expected fields describe outputs after the edge.
  typedef struct packed {
    logic        rst;
    logic        run;
    logic [3:0]  done;
    logic        mem;
    logic        ebr;
    logic        ecl;
    logic [2:0]  st;
    logic [3:0]  starts;
    logic [2:0]  wb;
    logic [1:0]  ht;
    logic [31:0] ret;
  } vec_t;

  typedef struct packed {
    logic [2:0]  st;
    logic [3:0]  starts;
    logic [2:0]  wb;
    logic [1:0]  ht;
    logic [31:0] ret;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tbl[24];

  function automatic vec_t v(input logic r, input logic rn, input logic [3:0] d,
                             input logic m, input logic eb, input logic ec,
                             input logic [2:0] st, input logic [3:0] sts,
                             input logic [2:0] wb, input logic [1:0] ht,
                             input logic [31:0] ret);
    v = '{rst: r, run: rn, done: d, mem: m, ebr: eb, ecl: ec,
          st: st, starts: sts, wb: wb, ht: ht, ret: ret};
  endfunction

  task automatic step(input vec_t t, input string name);
    exp_t       e;
    logic [11:0] got_ctl;
    @(negedge clk);
    rst        = t.rst;
    run        = t.run;
    ifu_done   = t.done[3];
    idu_done   = t.done[2];
    exu_done   = t.done[1];
    lsu_done   = t.done[0];
    mem_access = t.mem;
    is_ebreak  = t.ebr;
    is_ecall   = t.ecl;
    exp_q.push_back('{st: t.st, starts: t.starts, wb: t.wb, ht: t.ht, ret: t.ret});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      got_ctl = {state, ifu_start, idu_start, exu_start, lsu_start,
                 reg_wen, pc_we, pc_sel_trap, halted, timeout};
      n_cmp++;
      if (got_ctl !== {e.st, e.starts, e.wb, e.ht}) begin
        n_bad++;
        $display("FAIL %s ctl: got st=%0d starts=%b wb=%b ht=%b, want st=%0d starts=%b wb=%b ht=%b",
                 name, got_ctl[11:9], got_ctl[8:5], got_ctl[4:2], got_ctl[1:0],
                 e.st, e.starts, e.wb, e.ht);
      end
      n_cmp++;
      if (retired !== e.ret) begin
        n_bad++;
        $display("FAIL %s retired: got %0d want %0d", name, retired, e.ret);
      end
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0;
    ifu_done = 1'b0; idu_done = 1'b0; exu_done = 1'b0; lsu_done = 1'b0;
    mem_access = 1'b0; is_ebreak = 1'b0; is_ecall = 1'b0;

    // Back-to-back ALU instructions with all dones tied high, then a stalled/LSU one
    tbl[0]  = v(1, 0, 4'h0, 0, 0, 0, 0, 4'h0, 3'b000, 2'b00, 0);
    tbl[1]  = v(0, 1, 4'hF, 0, 0, 0, 1, 4'h8, 3'b000, 2'b00, 0);
    tbl[2]  = v(0, 1, 4'hF, 0, 0, 0, 2, 4'h4, 3'b000, 2'b00, 0);
    tbl[3]  = v(0, 1, 4'hF, 0, 0, 0, 3, 4'h2, 3'b000, 2'b00, 0);
    tbl[4]  = v(0, 1, 4'hF, 0, 0, 0, 5, 4'h0, 3'b110, 2'b00, 0);
    tbl[5]  = v(0, 1, 4'hF, 0, 0, 0, 1, 4'h8, 3'b000, 2'b00, 1);
    tbl[6]  = v(0, 1, 4'hF, 0, 0, 0, 2, 4'h4, 3'b000, 2'b00, 1);
    tbl[7]  = v(0, 1, 4'hF, 0, 0, 0, 3, 4'h2, 3'b000, 2'b00, 1);
    tbl[8]  = v(0, 1, 4'hF, 0, 0, 0, 5, 4'h0, 3'b110, 2'b00, 1);
    tbl[9]  = v(0, 1, 4'hF, 0, 0, 0, 1, 4'h8, 3'b000, 2'b00, 2);
    tbl[10] = v(0, 1, 4'hF, 0, 0, 0, 2, 4'h4, 3'b000, 2'b00, 2);
    tbl[11] = v(0, 1, 4'hF, 0, 0, 0, 3, 4'h2, 3'b000, 2'b00, 2);
    tbl[12] = v(0, 1, 4'hF, 0, 0, 0, 5, 4'h0, 3'b110, 2'b00, 2);
    tbl[13] = v(0, 1, 4'hF, 0, 0, 0, 1, 4'h8, 3'b000, 2'b00, 3);
    tbl[14] = v(0, 0, 4'h2, 0, 0, 0, 1, 4'h0, 3'b000, 2'b00, 3);
    tbl[15] = v(0, 0, 4'h8, 0, 0, 0, 2, 4'h4, 3'b000, 2'b00, 3);
    tbl[16] = v(0, 0, 4'h4, 1, 0, 0, 3, 4'h2, 3'b000, 2'b00, 3);
    tbl[17] = v(0, 0, 4'h2, 0, 0, 0, 4, 4'h1, 3'b000, 2'b00, 3);
    tbl[18] = v(0, 0, 4'hE, 0, 0, 0, 4, 4'h0, 3'b000, 2'b00, 3);
    tbl[19] = v(0, 0, 4'h0, 0, 0, 0, 4, 4'h0, 3'b000, 2'b00, 3);
    tbl[20] = v(0, 0, 4'h0, 0, 0, 0, 4, 4'h0, 3'b000, 2'b00, 3);
    tbl[21] = v(0, 0, 4'h1, 0, 0, 0, 5, 4'h0, 3'b110, 2'b00, 3);
    tbl[22] = v(0, 0, 4'h0, 0, 0, 0, 0, 4'h0, 3'b000, 2'b00, 4);
    tbl[23] = v(0, 0, 4'hF, 0, 0, 0, 0, 4'h0, 3'b000, 2'b00, 4);

    for (int i = 0; i < 24; i++) step(tbl[i], $sformatf("vec%0d", i));

    // ecall traps without a register write; the next instruction does not trap
    step(v(0, 1, 4'h0, 0, 0, 0, 1, 4'h8, 3'b000, 2'b00, 4), "ecall_if");
    step(v(0, 1, 4'h8, 0, 0, 0, 2, 4'h4, 3'b000, 2'b00, 4), "ecall_id");
    step(v(0, 1, 4'h4, 0, 0, 1, 3, 4'h2, 3'b000, 2'b00, 4), "ecall_ex");
    step(v(0, 1, 4'h2, 0, 0, 0, 5, 4'h0, 3'b011, 2'b00, 4), "ecall_wb");
    step(v(0, 1, 4'h0, 0, 0, 0, 1, 4'h8, 3'b000, 2'b00, 5), "post_ecall_if");
    step(v(0, 1, 4'h8, 0, 0, 0, 2, 4'h4, 3'b000, 2'b00, 5), "post_ecall_id");
    step(v(0, 1, 4'h4, 0, 0, 0, 3, 4'h2, 3'b000, 2'b00, 5), "post_ecall_ex");
    step(v(0, 1, 4'h2, 0, 0, 0, 5, 4'h0, 3'b110, 2'b00, 5), "post_ecall_wb");
    step(v(0, 0, 4'h0, 0, 0, 0, 0, 4'h0, 3'b000, 2'b00, 6), "post_ecall_idle");

    // Reset in LS aborts the instruction; IF resumes right after
    step(v(0, 1, 4'h0, 0, 0, 0, 1, 4'h8, 3'b000, 2'b00, 6), "rstls_if");
    step(v(0, 1, 4'h8, 0, 0, 0, 2, 4'h4, 3'b000, 2'b00, 6), "rstls_id");
    step(v(0, 1, 4'h4, 1, 0, 0, 3, 4'h2, 3'b000, 2'b00, 6), "rstls_ex");
    step(v(0, 1, 4'h2, 0, 0, 0, 4, 4'h1, 3'b000, 2'b00, 6), "rstls_ls");
    step(v(1, 1, 4'hF, 0, 0, 0, 0, 4'h0, 3'b000, 2'b00, 0), "rstls_rst");
    step(v(0, 1, 4'h0, 0, 0, 0, 1, 4'h8, 3'b000, 2'b00, 0), "rstls_resume");
    step(v(0, 1, 4'h8, 0, 0, 0, 2, 4'h4, 3'b000, 2'b00, 0), "rstls_id2");
    step(v(0, 1, 4'h4, 0, 0, 0, 3, 4'h2, 3'b000, 2'b00, 0), "rstls_ex2");
    step(v(0, 1, 4'h2, 0, 0, 0, 5, 4'h0, 3'b110, 2'b00, 0), "rstls_wb2");

    // ebreak together with ecall halts with no WB and no retire
    step(v(0, 1, 4'h0, 0, 0, 0, 1, 4'h8, 3'b000, 2'b00, 1), "ebr_if");
    step(v(0, 1, 4'h8, 0, 0, 0, 2, 4'h4, 3'b000, 2'b00, 1), "ebr_id");
    step(v(0, 1, 4'h4, 0, 1, 1, 6, 4'h0, 3'b000, 2'b10, 1), "ebr_halt");
    for (int i = 0; i < 20; i++)
      step(v(0, 1, 4'hF, 0, 1, 1, 6, 4'h0, 3'b000, 2'b10, 1), $sformatf("halt_hold%0d", i));
    step(v(1, 0, 4'h0, 0, 0, 0, 0, 4'h0, 3'b000, 2'b00, 0), "halt_rst");

    // Watchdog: exactly 8 cycles in EX with exu_done low, then ERR
    step(v(0, 1, 4'h0, 0, 0, 0, 1, 4'h8, 3'b000, 2'b00, 0), "wd_if");
    step(v(0, 1, 4'h8, 0, 0, 0, 2, 4'h4, 3'b000, 2'b00, 0), "wd_id");
    step(v(0, 1, 4'h4, 0, 0, 0, 3, 4'h2, 3'b000, 2'b00, 0), "wd_ex");
    for (int i = 0; i < 7; i++)
      step(v(0, 1, 4'hD, 0, 0, 0, 3, 4'h0, 3'b000, 2'b00, 0), $sformatf("wd_stall%0d", i));
    step(v(0, 1, 4'hD, 0, 0, 0, 7, 4'h0, 3'b000, 2'b11, 0), "wd_err");
    for (int i = 0; i < 3; i++)
      step(v(0, 1, 4'hF, 0, 0, 0, 7, 4'h0, 3'b000, 2'b11, 0), $sformatf("err_hold%0d", i));
    step(v(1, 0, 4'h0, 0, 0, 0, 0, 4'h0, 3'b000, 2'b00, 0), "err_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/npc_stage_ctrl.md
NPC_STAGE_CTRL -- requirements
Module: npc_stage_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 200, which sets the maximum number of cycles allowed in a stage state (1..255; counter is 8 bits).
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port run  in  1  enables instruction sequencing.
REQ-005 SHALL have ports ifu_done / idu_done / exu_done / lsu_done  in  1 each  stage-complete strobes.
REQ-006 SHALL have port mem_access  in  1  decoded instruction uses LSU; valid with idu_done.
REQ-007 SHALL have port is_ebreak  in  1  decoded ebreak; valid with idu_done.
REQ-008 SHALL have port is_ecall  in  1  decoded ecall; valid with idu_done.
REQ-009 SHALL have ports ifu_start / idu_start / exu_start / lsu_start  out  1 each  stage launch pulses.
REQ-010 SHALL have port reg_wen  out  1  register-file write enable.
REQ-011 SHALL have port pc_we  out  1  PC update strobe.
REQ-012 SHALL have port pc_sel_trap  out  1  when 1, the PC loads the trap vector instead of the next PC.
REQ-013 SHALL have port halted  out  1  core stopped, sticky until reset.
REQ-014 SHALL have port timeout  out  1  watchdog fired, sticky until reset.
REQ-015 SHALL have port state  out  3  current state: IDLE=0, IF=1, ID=2, EX=3, LS=4, WB=5, HALT=6, ERR=7.
REQ-016 SHALL have port retired  out  32  retired-instruction count.

Function
REQ-017 SHALL, from IDLE, go to IF in the cycle after run=1 is sampled; otherwise it stays in IDLE.
REQ-018 SHALL go from IF to ID on ifu_done.
REQ-019 SHALL, in ID on idu_done, go to HALT if is_ebreak=1, else to EX.
REQ-020 SHALL, in ID on idu_done, latch mem_access and is_ecall into internal flags.
REQ-021 SHALL, on exu_done, go from EX to LS if the latched mem flag is 1, else to WB.
REQ-022 SHALL go from LS to WB on lsu_done.
REQ-023 SHALL hold WB for exactly 1 cycle, then go to IF if run=1, else to IDLE.
REQ-024 SHALL drive each X_start high only in the first cycle state==X, with a single pulse per entry.
REQ-025 SHALL accept a done strobe arriving in the same cycle as its start pulse (zero-wait stage).
REQ-026 SHALL ignore done strobes outside their matching state.
REQ-027 SHALL, in WB: pc_we=1; reg_wen=1 unless the latched ecall flag is set (then reg_wen=0); pc_sel_trap = latched ecall flag.
REQ-028 SHALL increment retired by 1 in WB, wrapping modulo 2^32.
REQ-029 SHALL keep reg_wen, pc_we and pc_sel_trap at 0 outside WB.
REQ-030 SHALL, when is_ebreak and is_ecall are both 1, take ebreak (HALT, no WB, no retire).
REQ-031 SHALL let run=0 mid-instruction finish the current instruction through WB before returning to IDLE.
REQ-032 SHALL keep HALT absorbing: halted=1, all starts 0, and run is ignored.
REQ-033 SHALL clear the watchdog counter on every state entry and increment it each cycle spent in IF/ID/EX/LS without the matching done.
REQ-034 SHALL enter ERR after TIMEOUT cycles in one stage state without the matching done; ERR sets timeout=1 and halted=1 and is absorbing.
REQ-035 SHALL clear the latched flags on each entry to IF.

Reset
REQ-036 SHALL have rst=1 override every transition and input.
REQ-037 SHALL, on the next edge after rst=1: state=IDLE; all outputs 0; retired=0; watchdog=0; flags cleared, including halted and timeout.
REQ-038 SHALL abort any instruction in progress when reset is asserted, with no WB side effects.

Verification
REQ-039 SHALL be verified by: reset, run=1, all done tied 1, mem_access=0 -> states cycle 1,2,3,5; ifu_start at cycles 1,5,9; retired=3 after cycle 12.
REQ-040 SHALL be verified by: mem_access=1 at idu_done, lsu_done 3 cycles after lsu_start -> LS dwell of 4 cycles, one lsu_start pulse, then a single WB with reg_wen=1.
REQ-041 SHALL be verified by: is_ebreak=1 at idu_done -> state=6 next cycle, halted=1, retired unchanged, no start pulse for 20 cycles with run=1.
REQ-042 SHALL be verified by: is_ecall=1 at idu_done -> WB with reg_wen=0, pc_we=1, pc_sel_trap=1; next instruction has pc_sel_trap=0.
REQ-043 SHALL be verified by: TIMEOUT=8, exu_done held 0 -> exactly 8 cycles in EX, then state=7, timeout=1, halted=1.
REQ-044 SHALL be verified by: rst pulsed while state=4 -> next cycle state=0, all outputs 0, retired=0; with run=1, IF resumes the following cycle.
